// File: rtl/twos_to_bipolar_stream.sv
// Streaming two's-complement to bipolar (p/n magnitude) converter for CIM wordline drive.
// Delivers each accepted vector as one parallel beat or as B_eff LSB-first serial beats.
module twos_to_bipolar_stream #(
  parameter int inBits   = 8,
  parameter int numLanes = 32
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [numLanes*inBits-1:0]   twos,
  input  logic [3:0]                   input_bits,
  input  logic                         serial_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [numLanes*inBits-1:0]   bipolar_p,
  output logic [numLanes*inBits-1:0]   bipolar_n,
  output logic [numLanes-1:0]          ser_p,
  output logic [numLanes-1:0]          ser_n,
  output logic [3:0]                   out_bit_idx,
  output logic                         out_last,
  output logic [1:0]                   dbg_state
);

  // Handshake: a vector transfers on a cycle where in_valid && in_ready; an output
  // beat transfers where out_valid && out_ready. Nothing else moves the pipeline.

  localparam int W1 = inBits + 1;
  localparam int LW = numLanes * inBits;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAR  = 2'd1,
    SER  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [4:0]           beff_q, beff_d;
  logic [LW-1:0]        bipolar_p_q, bipolar_p_d;
  logic [LW-1:0]        bipolar_n_q, bipolar_n_d;
  logic [numLanes-1:0]  ser_p_q, ser_p_d;
  logic [numLanes-1:0]  ser_n_q, ser_n_d;

  logic                 accept;
  logic [4:0]           bits_ext;
  logic [4:0]           beff_in;
  logic [W1-1:0]        pow;
  logic [W1-1:0]        lane_val;
  logic [LW-1:0]        conv_p, conv_n;
  logic [LW-1:0]        src_p, src_n;
  logic [3:0]           idx_next;
  logic [3:0]           sidx;
  logic [inBits-1:0]    tmp_p, tmp_n;
  logic [numLanes-1:0]  sel_p, sel_n;

  assign in_ready = !out_valid_q || (out_ready && out_last_q);
  assign accept   = in_valid && in_ready;
  assign bits_ext = {1'b0, input_bits};
  assign beff_in  = (bits_ext != 5'd0 && bits_ext <= 5'(inBits)) ? bits_ext : 5'(inBits);
  assign idx_next = bit_idx_q + 4'd1;

  // Sign-extend-free conversion: negative magnitude is 2^B_eff minus the raw field,
  // which yields 2^(B_eff-1) for the most negative code without overflow.
  always_comb begin
    pow      = W1'(1) << beff_in;
    lane_val = '0;
    conv_p   = '0;
    conv_n   = '0;
    for (int i = 0; i < numLanes; i++) begin
      lane_val = {1'b0, twos[i*inBits +: inBits]} & (pow - W1'(1));
      if ((lane_val & (pow >> 1)) != '0) begin
        conv_n[i*inBits +: inBits] = inBits'(pow - lane_val);
      end else begin
        conv_p[i*inBits +: inBits] = lane_val[inBits-1:0];
      end
    end
  end

  // Serial bit for the beat being loaded: bit 0 of new data, or bit k+1 of held data.
  always_comb begin
    src_p = accept ? conv_p : bipolar_p_q;
    src_n = accept ? conv_n : bipolar_n_q;
    sidx  = accept ? 4'd0 : idx_next;
    tmp_p = '0;
    tmp_n = '0;
    sel_p = '0;
    sel_n = '0;
    for (int i = 0; i < numLanes; i++) begin
      tmp_p    = src_p[i*inBits +: inBits] >> sidx;
      tmp_n    = src_n[i*inBits +: inBits] >> sidx;
      sel_p[i] = tmp_p[0];
      sel_n[i] = tmp_n[0];
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    bit_idx_d   = bit_idx_q;
    beff_d      = beff_q;
    bipolar_p_d = bipolar_p_q;
    bipolar_n_d = bipolar_n_q;
    ser_p_d     = ser_p_q;
    ser_n_d     = ser_n_q;
    if (accept) begin
      state_d     = serial_mode ? SER : PAR;
      out_valid_d = 1'b1;
      out_last_d  = serial_mode ? (beff_in == 5'd1) : 1'b1;
      bit_idx_d   = 4'd0;
      beff_d      = beff_in;
      bipolar_p_d = conv_p;
      bipolar_n_d = conv_n;
      ser_p_d     = serial_mode ? sel_p : '0;
      ser_n_d     = serial_mode ? sel_n : '0;
    end else if (out_valid_q && out_ready) begin
      if (out_last_q) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        bit_idx_d   = 4'd0;
        ser_p_d     = '0;
        ser_n_d     = '0;
      end else begin
        bit_idx_d  = idx_next;
        out_last_d = ({1'b0, idx_next} == beff_q - 5'd1);
        ser_p_d    = sel_p;
        ser_n_d    = sel_n;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      bit_idx_q   <= 4'd0;
      beff_q      <= 5'd0;
      bipolar_p_q <= '0;
      bipolar_n_q <= '0;
      ser_p_q     <= '0;
      ser_n_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      bit_idx_q   <= bit_idx_d;
      beff_q      <= beff_d;
      bipolar_p_q <= bipolar_p_d;
      bipolar_n_q <= bipolar_n_d;
      ser_p_q     <= ser_p_d;
      ser_n_q     <= ser_n_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_bit_idx = bit_idx_q;
  assign bipolar_p   = bipolar_p_q;
  assign bipolar_n   = bipolar_n_q;
  assign ser_p       = ser_p_q;
  assign ser_n       = ser_n_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_twos_to_bipolar_stream.sv
// Directed bench for twos_to_bipolar_stream with 4 lanes of 8 bits; lane 0 sits in the LSBs.
module tb_twos_to_bipolar_stream;

  localparam int IB = 8;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   twos;
  logic [3:0]    input_bits;
  logic          serial_mode;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   bipolar_p;
  logic [31:0]   bipolar_n;
  logic [3:0]    ser_p;
  logic [3:0]    ser_n;
  logic [3:0]    out_bit_idx;
  logic          out_last;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  twos_to_bipolar_stream #(.inBits(IB), .numLanes(NL)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .twos(twos),
    .input_bits(input_bits), .serial_mode(serial_mode), .out_valid(out_valid),
    .out_ready(out_ready), .bipolar_p(bipolar_p), .bipolar_n(bipolar_n),
    .ser_p(ser_p), .ser_n(ser_n), .out_bit_idx(out_bit_idx), .out_last(out_last),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bits;
    logic [31:0] twos;
    logic [31:0] exp_p;
    logic [31:0] exp_n;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mag_n;
    logic [7:0] mag_p;
    logic [3:0] oor_bits[2];
    int         beats;

    vecs[0] = '{4'd8,  32'h8000FD05, 32'h00000005, 32'h80000300};
    vecs[1] = '{4'd4,  32'h07080F1A, 32'h07000000, 32'h00080106};
    vecs[2] = '{4'd0,  32'h01FF817F, 32'h0100007F, 32'h00017F00};
    vecs[3] = '{4'd12, 32'h00C04080, 32'h00004000, 32'h00400080};
    vecs[4] = '{4'd1,  32'h0203FE01, 32'h00000000, 32'h00010001};
    vecs[5] = '{4'd2,  32'hFC030102, 32'h00000100, 32'h00010002};
    vecs[6] = '{4'd15, 32'h10857EFF, 32'h10007E00, 32'h007B0001};
    vecs[7] = '{4'd3,  32'h07040B05, 32'h00000300, 32'h01040003};
    oor_bits[0] = 4'd0;
    oor_bits[1] = 4'd12;

    nrst = 1'b0; in_valid = 1'b0; twos = '0; input_bits = 4'd8;
    serial_mode = 1'b0; out_ready = 1'b0;
    #2;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst bipolar_p", bipolar_p, 0);
    check("rst bipolar_n", bipolar_n, 0);
    check("rst out_last", out_last, 0);
    #10 nrst = 1'b1;
    step();
    check("idle out_valid", out_valid, 0);

    // Parallel vectors back to back with out_ready held high.
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1; serial_mode = 1'b0;
      input_bits = vecs[v].bits; twos = vecs[v].twos;
      #1;
      check($sformatf("par%0d in_ready", v), in_ready, 1);
      step();
      check($sformatf("par%0d out_valid", v), out_valid, 1);
      check($sformatf("par%0d out_last", v), out_last, 1);
      check($sformatf("par%0d bit_idx", v), out_bit_idx, 0);
      check($sformatf("par%0d bipolar_p", v), bipolar_p, vecs[v].exp_p);
      check($sformatf("par%0d bipolar_n", v), bipolar_n, vecs[v].exp_n);
    end
    in_valid = 1'b0;
    step();
    check("par drain out_valid", out_valid, 0);
    check("par drain in_ready", in_ready, 1);
    check("par drain holds p", bipolar_p, vecs[7].exp_p);

    // Serial B=4: lane0 = -5 (n=0101), lane1 = +6 (p=0110).
    in_valid = 1'b1; serial_mode = 1'b1; input_bits = 4'd4; twos = 32'h000006FB;
    step();
    in_valid = 1'b0;
    mag_n = 8'h05; mag_p = 8'h06;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ser k%0d out_valid", k), out_valid, 1);
      check($sformatf("ser k%0d bit_idx", k), out_bit_idx, k);
      check($sformatf("ser k%0d ser_n", k), ser_n, {3'b000, mag_n[k]});
      check($sformatf("ser k%0d ser_p", k), ser_p, {2'b00, mag_p[k], 1'b0});
      check($sformatf("ser k%0d out_last", k), out_last, (k == 3));
      check($sformatf("ser k%0d in_ready", k), in_ready, (k == 3));
      check($sformatf("ser k%0d bipolar_n", k), bipolar_n, 32'h00000005);
      step();
    end
    check("ser end out_valid", out_valid, 0);

    // Serial B=2 then stall at k=1, then parallel with no bubble.
    in_valid = 1'b1; serial_mode = 1'b1; input_bits = 4'd2; twos = 32'h00000102;
    step();
    check("b2b k0 ser_p", ser_p, 4'b0010);
    check("b2b k0 ser_n", ser_n, 4'b0000);
    in_valid = 1'b0;
    step();
    check("b2b k1 bit_idx", out_bit_idx, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; serial_mode = 1'b1; input_bits = 4'd1; twos = vecs[0].twos;
    #1;
    check("stall in_ready", in_ready, 0);
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("stall%0d bit_idx", s), out_bit_idx, 1);
      check($sformatf("stall%0d ser_n", s), ser_n, 4'b0001);
      check($sformatf("stall%0d out_last", s), out_last, 1);
      check($sformatf("stall%0d out_valid", s), out_valid, 1);
      check($sformatf("stall%0d bipolar_n", s), bipolar_n, 32'h00000002);
    end
    serial_mode = 1'b0; input_bits = 4'd8; out_ready = 1'b1;
    #1;
    check("resume in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("resume out_valid", out_valid, 1);
    check("resume bit_idx", out_bit_idx, 0);
    check("resume bipolar_p", bipolar_p, vecs[0].exp_p);
    check("resume bipolar_n", bipolar_n, vecs[0].exp_n);
    step();
    check("resume drain", out_valid, 0);

    // Out-of-range precision in serial mode: 8 beats; mid-transaction changes ignored.
    for (int r = 0; r < 2; r++) begin
      in_valid = 1'b1; serial_mode = 1'b1; input_bits = oor_bits[r]; twos = 32'h00005581;
      step();
      in_valid = 1'b0; input_bits = 4'd3; serial_mode = 1'b0;
      mag_n = 8'h7F; mag_p = 8'h55;
      beats = 0;
      while (out_valid && beats < 20) begin
        check($sformatf("oor%0d k%0d ser_n", r, beats), ser_n[0], mag_n[beats[2:0]]);
        check($sformatf("oor%0d k%0d ser_p", r, beats), ser_p[1], mag_p[beats[2:0]]);
        beats++;
        step();
      end
      check($sformatf("oor%0d beat count", r), beats, 8);
    end

    // Reset at k=2 of a B=8 serial transaction.
    in_valid = 1'b1; serial_mode = 1'b1; input_bits = 4'd8; twos = 32'h000000FB;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("prerst bit_idx", out_bit_idx, 2);
    #2 nrst = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst bit_idx", out_bit_idx, 0);
    check("midrst ser_n", ser_n, 0);
    check("midrst ser_p", ser_p, 0);
    check("midrst bipolar_n", bipolar_n, 0);
    check("midrst out_last", out_last, 0);
    step();
    #3 nrst = 1'b1;
    step();
    check("postrst out_valid", out_valid, 0);
    in_valid = 1'b1; serial_mode = 1'b1; input_bits = 4'd4; twos = 32'h000000FB;
    step();
    in_valid = 1'b0;
    check("postrst bit_idx", out_bit_idx, 0);
    check("postrst ser_n", ser_n, 4'b0001);
    check("postrst bipolar_n", bipolar_n, 32'h00000005);
    check("postrst out_valid", out_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/twos_to_bipolar_stream.md
# twos_to_bipolar_stream

Streaming, multi-lane successor to the combinational two's-complement to bipolar converter. It accepts a vector of signed activations under a valid/ready handshake and splits each lane into a non-negative positive-rail magnitude and a non-negative negative-rail magnitude. It delivers them either as one registered parallel word (parallel mode) or LSB-first over `input_bits` beats for bit-serial wordline drive (serial mode). It sits between the activation buffer and the CIM array wordline drivers.

## Interface
- `inBits`, default 8: lane width; the maximum supported precision.
- `numLanes`, default 32: number of parallel lanes.
- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an input vector is presented.
- `in_ready`  out  1  the block accepts the vector this cycle.
- `twos`  in  numLanes×inBits  signed lane values.
- `input_bits`  in  4  active precision B; sampled at acceptance.
- `serial_mode`  in  1  0 = parallel, 1 = bit-serial; sampled at acceptance.
- `out_valid`  out  1  an output beat is valid.
- `out_ready`  in  1  the downstream stage consumes the beat.
- `bipolar_p`  out  numLanes×inBits  positive-rail magnitudes, held for the whole transaction.
- `bipolar_n`  out  numLanes×inBits  negative-rail magnitudes, held for the whole transaction.
- `ser_p`  out  numLanes  serial-mode bit k of `bipolar_p`, one bit per lane.
- `ser_n`  out  numLanes  serial-mode bit k of `bipolar_n`, one bit per lane.
- `out_bit_idx`  out  4  current serial bit index k; 0 in parallel mode.
- `out_last`  out  1  final beat of the transaction.

## Operation
- **Effective precision.** B_eff = `input_bits` if 1 ≤ `input_bits` ≤ `inBits`. Otherwise B_eff = `inBits`.
- **Lane interpretation.** Each lane is the signed value held in its low B_eff bits, with bit B_eff-1 as the sign. Bits at or above B_eff are ignored.
- **Zero lanes.** A lane value of 0 gives p = 0 and n = 0.
- **Positive lanes.** A lane value v > 0 gives p = v and n = 0.
- **Negative lanes.** A lane value v < 0 gives p = 0 and n = -v, computed as an unsigned magnitude of B_eff bits.
  - The most negative value -2^(B_eff-1) gives n = 2^(B_eff-1); there is no overflow.
  - Upper bits of each output lane are zero.
- **Capture.** On acceptance, the block registers the magnitudes, B_eff and the mode. They stay stable until the transaction retires.
- **State machine.** States are IDLE, PAR and SER.
  - IDLE: `out_valid` = 0, `in_ready` = 1. Acceptance moves to PAR if `serial_mode` = 0, or to SER with k = 0 if `serial_mode` = 1.
  - PAR: one beat, with `out_last` = 1. When `out_ready` = 1 the beat retires and the state goes to IDLE, or reloads if a new vector is accepted in the same cycle.
  - SER: beat k drives `ser_p[i]` = `bipolar_p[i][k]`, `ser_n[i]` = `bipolar_n[i][k]`, `out_bit_idx` = k, and `out_last` = (k == B_eff-1).
  - In SER, `out_ready` = 1 with k < B_eff-1 increments k.
  - In SER, `out_ready` = 1 with k = B_eff-1 retires the transaction, with the same reload rule as PAR.
- **Ready rule.** `in_ready` = !`out_valid` || (`out_ready` && `out_last`). It is combinational from state and `out_ready`.
- **Simultaneous retire and accept.** The new vector loads and `out_valid` stays 1 with no bubble. The next state follows the new `serial_mode`, and k restarts at 0.
- **Stall.** With `out_ready` = 0, every output holds its value and k does not advance.
- **Mode and precision changes.** These take effect only at acceptance. Changing `input_bits` or `serial_mode` mid-transaction has no effect.
- **Reset.** Asserting `nrst` low, including mid-transaction, gives the following immediately (asynchronously), with no output pulse on release:
  - State goes to IDLE.
  - `out_valid`, `out_last`, `out_bit_idx`, `ser_p`, `ser_n`, `bipolar_p` and `bipolar_n` go to 0.
  - `in_ready` goes to 1.

## Timing
- **Latency.** Acceptance at edge t gives the first output beat valid from t+1.
- **Parallel throughput.** One vector per cycle when `out_ready` is held at 1.
- **Serial throughput.** One vector per B_eff cycles, with transactions back-to-back and no idle cycle between them.
- **Output stability.** Outputs are registered, except `in_ready`, and change only on beat advance, acceptance or reset.

## Test plan
- **Parallel basic.** numLanes = 4, B = 8, lanes {5, -3, 0, -128}, `out_ready` = 1.
  - Cycle t+1: p = {5, 0, 0, 0}, n = {0, 3, 0, 128}, `out_last` = 1.
- **Reduced precision.** B = 4, lane 0x1A (low nibble 0xA = -6) → p = 0, n = 6. Lane 0x0F (-1) → n = 1. Lane 0x08 (-8) → n = 8.
- **Serial beats.** B = 4, lane -5 → n = 5 (0b0101).
  - Beats k = 0..3 give `ser_n` = 1, 0, 1, 0 and `ser_p` = 0.
  - `out_last` = 1 only at k = 3; `in_ready` = 0 during beats 0–2.
- **Back-to-back with stall.** A serial transaction (B = 2) is followed immediately by a parallel one.
  - Deassert `out_ready` for 3 cycles at k = 1: outputs hold and k stays 1.
  - Reassert `out_ready` with `in_valid` = 1: the new vector appears the next cycle with `out_bit_idx` = 0 and no bubble.
- **Out-of-range precision.** `input_bits` = 0 and `input_bits` = 12 with `inBits` = 8 behave as B = 8, and serial mode produces 8 beats.
- **Reset mid-serial.** Drop `nrst` at k = 2 of a B = 8 transaction.
  - All outputs go to 0 and `in_ready` = 1 immediately.
  - After release, the first accepted vector starts at k = 0 with correct values.
